// File: rtl/mips_fetch_pkg.sv
// Shared constants and types for the fetch_unit instruction-fetch stage.
package mips_fetch_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 32;

  // Program windows [base, limit) indexed by prog_sel; entry 3 is the reserved selector.
  localparam logic [3:0][31:0] PROG_BASE  = {32'd0, 32'd30, 32'd15, 32'd0};
  localparam logic [3:0][31:0] PROG_LIMIT = {32'd0, 32'd81, 32'd30, 32'd15};
  localparam logic [1:0]       PROG_RESERVED = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between fetch_unit (master) and its environment: control, instruction memory,
// execute redirects and the decoder handshake.
interface fetch_unit_if #(
  parameter int ADDR_W = mips_fetch_pkg::ADDR_W_DEFAULT,
  parameter int DATA_W = mips_fetch_pkg::DATA_W_DEFAULT
);
  import mips_fetch_pkg::*;

  logic              start;
  logic [1:0]        prog_sel;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  // instr_valid/instr_ready: a word transfers on a rising edge where both are high; once raised,
  // instr_valid with instr/instr_pc holds steady until that transfer or a redirect flush.
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              running;
  logic              halted;
  logic              fault;
  fetch_state_e      dbg_state;

  modport master (
    input  start, prog_sel, imem_data, redirect_valid, redirect_pc, instr_ready,
    output imem_addr, instr, instr_pc, instr_valid, running, halted, fault, dbg_state
  );

  modport slave (
    output start, prog_sel, imem_data, redirect_valid, redirect_pc, instr_ready,
    input  imem_addr, instr, instr_pc, instr_valid, running, halted, fault, dbg_state
  );

endinterface

// File: rtl/fetch_perf_counters.sv
// Saturating counters of decoder-accepted instructions and stall cycles for fetch_unit.
module fetch_perf_counters (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_clear,
  input  logic        i_fetch_inc,
  input  logic        i_stall_inc,
  output logic [15:0] o_fetch_count,
  output logic [15:0] o_stall_count
);

  logic [15:0] r_fetch_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else if (i_clear) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (i_fetch_inc && (r_fetch_count != 16'hFFFF)) r_fetch_count <= r_fetch_count + 16'd1;
      if (i_stall_inc && (r_stall_count != 16'hFFFF)) r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
  assign o_stall_count = r_stall_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction-memory addressing, IF/ID register and redirects.
// Build option FETCH_PERF_CNT_EN adds fetch_count/stall_count outputs.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]  fetch_count,
  output logic [15:0]  stall_count
`endif
);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_limit;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_pend_valid;
  logic              r_instr_valid;
  logic              r_fault;

  logic              w_active;
  logic              w_launch;
  logic              w_sel_ok;
  logic [ADDR_W-1:0] w_sel_base;
  logic [ADDR_W-1:0] w_sel_limit;
  logic              w_redir;
  logic              w_redir_ok;
  logic              w_stall;
  logic              w_issue;
  logic              w_load;
  logic [ADDR_W-1:0] w_imem_addr;

  assign w_active    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign w_launch    = bus.start && ((r_state == ST_IDLE) || (r_state == ST_HALT));
  assign w_sel_ok    = (bus.prog_sel != PROG_RESERVED);
  assign w_sel_base  = ADDR_W'(PROG_BASE[bus.prog_sel]);
  assign w_sel_limit = ADDR_W'(PROG_LIMIT[bus.prog_sel]);
  assign w_redir     = w_active && bus.redirect_valid;
  assign w_redir_ok  = w_redir && (bus.redirect_pc >= r_base) && (bus.redirect_pc < r_limit);
  assign w_stall     = r_instr_valid && !bus.instr_ready;
  assign w_issue     = (r_state == ST_RUN) && !w_stall && (r_fetch_pc != r_limit);
  assign w_load      = r_pend_valid && (!r_instr_valid || bus.instr_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) w_next_state = w_sel_ok ? ST_RUN : ST_HALT;
      end
      ST_RUN, ST_DRAIN: begin
        if (w_redir) w_next_state = w_redir_ok ? ST_RUN : ST_HALT;
        else if ((r_state == ST_RUN) && (r_fetch_pc == r_limit)) w_next_state = ST_DRAIN;
        else if ((r_state == ST_DRAIN) && !r_pend_valid && !r_instr_valid) w_next_state = ST_HALT;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Re-presenting pend_pc while not issuing keeps the memory's registered word steady.
  always_comb begin
    w_imem_addr = '0;
    if (w_redir_ok)    w_imem_addr = bus.redirect_pc;
    else if (w_issue)  w_imem_addr = r_fetch_pc;
    else if (w_active) w_imem_addr = r_pend_pc;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc    <= '0;
      r_pend_pc     <= '0;
      r_base        <= '0;
      r_limit       <= '0;
      r_instr_pc    <= '0;
      r_instr       <= '0;
      r_pend_valid  <= 1'b0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else if (w_launch) begin
      r_base        <= w_sel_base;
      r_limit       <= w_sel_limit;
      r_fetch_pc    <= w_sel_base;
      r_fault       <= !w_sel_ok;
      r_pend_valid  <= 1'b0;
      r_instr_valid <= 1'b0;
    end else if (w_redir) begin
      r_instr_valid <= 1'b0;
      if (w_redir_ok) begin
        r_pend_pc    <= bus.redirect_pc;
        r_pend_valid <= 1'b1;
        r_fetch_pc   <= bus.redirect_pc + 1'b1;
      end else begin
        r_pend_valid <= 1'b0;
        r_fault      <= 1'b1;
      end
    end else begin
      if (w_load) begin
        r_instr       <= bus.imem_data;
        r_instr_pc    <= r_pend_pc;
        r_instr_valid <= 1'b1;
      end else if (bus.instr_ready) begin
        r_instr_valid <= 1'b0;
      end
      if (w_issue) begin
        r_pend_pc    <= r_fetch_pc;
        r_pend_valid <= 1'b1;
        r_fetch_pc   <= r_fetch_pc + 1'b1;
      end else if (w_load) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  assign bus.imem_addr   = w_imem_addr;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.running     = w_active;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.fault       = r_fault;
  assign bus.dbg_state   = r_state;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_clear       (w_launch),
    .i_fetch_inc   (r_instr_valid && bus.instr_ready),
    .i_stall_inc   (w_stall),
    .o_fetch_count (fetch_count),
    .o_stall_count (stall_count)
  );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: launch vector table, hand-built stall/redirect/fault/reset sequences and
// randomized runs checked against an in-order expected-address queue.
module tb_fetch_unit;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int NMEM = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;
`endif

  fetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  // Registered instruction memory: word appears the cycle after its address.
  logic [DW-1:0] mem [NMEM];
  always @(posedge clock) bus.imem_data <= mem[bus.imem_addr];

  // ---------------- reference model / scoreboard ----------------
  int base_tab  [4] = '{0, 15, 30, 0};
  int limit_tab [4] = '{15, 30, 81, 0};
  int cur_base;
  int cur_limit;
  logic [AW-1:0] exp_q [$];
  int accepted;
  int errors;
  int checks;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_queue(input int from, input int to);
    exp_q.delete();
    for (int a = from; a < to; a++) exp_q.push_back(AW'(a));
  endtask

  // ---------------- driver tasks ----------------
  // Scores the handshake about to happen, applies any redirect to the model, then advances one edge.
  task automatic tick();
    logic [AW-1:0] exp_pc;
    if (bus.instr_valid && bus.instr_ready) begin
      checks++;
      accepted++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_extra: actual pc=%0d required=no further word", bus.instr_pc);
      end else begin
        exp_pc = exp_q.pop_front();
        if ((bus.instr_pc !== exp_pc) || (bus.instr !== mem[exp_pc])) begin
          errors++;
          $display("FAIL stream_word: actual pc=%0d data=%0h required pc=%0d data=%0h",
                   bus.instr_pc, bus.instr, exp_pc, mem[exp_pc]);
        end
      end
    end
    if (bus.redirect_valid && bus.running) begin
      if ((int'(bus.redirect_pc) >= cur_base) && (int'(bus.redirect_pc) < cur_limit))
        fill_queue(int'(bus.redirect_pc), cur_limit);
      else
        exp_q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic [1:0] p);
    bus.prog_sel = p;
    bus.start    = 1'b1;
    if (!bus.running) begin
      cur_base  = base_tab[p];
      cur_limit = limit_tab[p];
      fill_queue(cur_base, cur_limit);
      accepted  = 0;
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_to_halt(input bit rand_ready, input int max_redirects, input int budget,
                             output int n_cycles);
    int redirs;
    redirs   = 0;
    n_cycles = 0;
    while ((n_cycles < budget) && !bus.halted) begin
      bus.instr_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if ((redirs < max_redirects) && bus.running && ($urandom_range(0, 15) == 0)) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = AW'($urandom_range(cur_base, cur_limit - 1));
        redirs++;
      end else if (rand_ready && bus.running && ($urandom_range(0, 31) == 0)) begin
        bus.start    = 1'b1;
        bus.prog_sel = 2'($urandom_range(0, 3));
      end
      tick();
      bus.redirect_valid = 1'b0;
      bus.start          = 1'b0;
      n_cycles++;
    end
    check("halt_reached", bus.halted, 1);
    check("stream_complete", exp_q.size(), 0);
    check("halt_valid_low", bus.instr_valid, 0);
  endtask

  task automatic wait_pc(input int pc);
    bit found;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus.instr_valid && (int'(bus.instr_pc) == pc)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("reach_pc", found, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_addr"}, bus.imem_addr, 0);
    check({tag, "_instr"}, bus.instr, 0);
    check({tag, "_instr_pc"}, bus.instr_pc, 0);
    check({tag, "_instr_valid"}, bus.instr_valid, 0);
    check({tag, "_running"}, bus.running, 0);
    check({tag, "_halted"}, bus.halted, 0);
    check({tag, "_fault"}, bus.fault, 0);
  endtask

  // ---------------- launch vector table ----------------
  typedef struct {
    logic [1:0] prog;
    logic       exp_fault;
    int         exp_base;
    int         exp_n;
  } launch_vec_t;

  launch_vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    errors   = 0;
    checks   = 0;
    accepted = 0;
    for (int a = 0; a < NMEM; a++) mem[a] = $urandom;
    bus.start          = 1'b0;
    bus.prog_sel       = 2'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b1;

    vecs[0] = '{2'd0, 1'b0, 0, 15};
    vecs[1] = '{2'd1, 1'b0, 15, 15};
    vecs[2] = '{2'd2, 1'b0, 30, 51};
    vecs[3] = '{2'd3, 1'b1, 0, 0};

    #2 reset_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_reset_outputs("idle");

    // Table: each program from IDLE/HALT with decoder always ready.
    for (int i = 0; i < 4; i++) begin
      bus.instr_ready = 1'b1;
      launch(vecs[i].prog);
      check("launch_fault", bus.fault, vecs[i].exp_fault);
      if (vecs[i].exp_fault) begin
        check("bad_sel_halted", bus.halted, 1);
        check("bad_sel_imem_addr", bus.imem_addr, 0);
        check("bad_sel_running", bus.running, 0);
      end else begin
        check("launch_running", bus.running, 1);
        check("launch_imem_addr", bus.imem_addr, vecs[i].exp_base);
        tick();
        check("e1_valid", bus.instr_valid, 0);
        tick();
        check("e2_valid", bus.instr_valid, 1);
        check("e2_pc", bus.instr_pc, vecs[i].exp_base);
        run_to_halt(1'b0, 0, 200, n);
        check("halt_cycles", n, vecs[i].exp_n + 1);
        check("accepted", accepted, vecs[i].exp_n);
        check("halt_fault", bus.fault, 0);
      end
    end

    // Stall of three cycles while pc 17 is presented.
    bus.instr_ready = 1'b1;
    launch(2'd1);
    wait_pc(17);
    bus.instr_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", bus.instr_valid, 1);
      check("stall_pc", bus.instr_pc, 17);
      check("stall_data", bus.instr, mem[17]);
      check("stall_imem_addr", bus.imem_addr, 18);
      tick();
    end
    bus.instr_ready = 1'b1;
    run_to_halt(1'b0, 0, 100, n);

    // Backward redirect to 6 while 9 is presented.
    launch(2'd0);
    wait_pc(9);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd6;
    #1;
    check("redir_imem_addr", bus.imem_addr, 6);
    tick();
    bus.redirect_valid = 1'b0;
    check("redir_flush", bus.instr_valid, 0);
    tick();
    check("redir_target_valid", bus.instr_valid, 1);
    check("redir_target_pc", bus.instr_pc, 6);
    run_to_halt(1'b0, 0, 100, n);

    // Out-of-window redirect faults; a new start recovers.
    launch(2'd1);
    wait_pc(20);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 10'd40;
    tick();
    bus.redirect_valid = 1'b0;
    check("oow_fault", bus.fault, 1);
    check("oow_halted", bus.halted, 1);
    check("oow_valid", bus.instr_valid, 0);
    tick();
    tick();
    check("oow_hold_valid", bus.instr_valid, 0);
    launch(2'd2);
    check("relaunch_fault_clear", bus.fault, 0);
    tick();
    tick();
    check("relaunch_valid", bus.instr_valid, 1);
    check("relaunch_pc", bus.instr_pc, 30);
    run_to_halt(1'b1, 0, 400, n);

    // Reserved selector, then asynchronous reset in the middle of program 2.
    launch(2'd3);
    check("sel3_halted", bus.halted, 1);
    check("sel3_fault", bus.fault, 1);
    check("sel3_imem_addr", bus.imem_addr, 0);
    launch(2'd2);
    bus.instr_ready = 1'b1;
    repeat (10) tick();
    check("pre_reset_running", bus.running, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;
    exp_q.delete();
    check("post_reset_state_idle", bus.running | bus.halted, 0);

    // Randomized runs: random ready, in-window redirects, ignored starts while running.
    for (int r = 0; r < 8; r++) begin
      launch(2'($urandom_range(0, 2)));
      run_to_halt(1'b1, 3, 3000, n);
    end

`ifdef FETCH_PERF_CNT_EN
    bus.instr_ready = 1'b1;
    launch(2'd0);
    tick();
    tick();
    bus.instr_ready = 1'b0;
    repeat (4) tick();
    bus.instr_ready = 1'b1;
    run_to_halt(1'b0, 0, 100, n);
    check("perf_fetch_count", fetch_count, 15);
    check("perf_stall_count", stall_count, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly upstream of the instruction memory. It owns the program counter, drives the memory address, and captures the memory's registered instruction word into an IF/ID output register with a valid/ready handshake toward the decoder. It accepts branch/jump redirects from execute and confines fetch to the address window of the selected program.

## Interface
- ADDR_W, 10, instruction address width (word addresses)
- DATA_W, 32, instruction width

- clock  in  1  rising-edge clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; launches selected program from IDLE or HALT
- prog_sel  in  2  0 fibonacci, 1 factorial, 2 synthetic, 3 reserved
- imem_addr  out  ADDR_W  address to instruction memory
- imem_data  in  DATA_W  memory word, valid the cycle after its address was presented
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  redirect target
- instr  out  DATA_W  instruction to decoder
- instr_pc  out  ADDR_W  address of `instr`
- instr_valid  out  1  `instr` valid
- instr_ready  in  1  decoder accepts `instr`
- running  out  1  state is RUN or DRAIN
- halted  out  1  state is HALT
- fault  out  1  sticky; bad prog_sel or out-of-window redirect

## Operation
- Program windows [base, limit): prog 0 [0,15), prog 1 [15,30), prog 2 [30,81). Window latched at start.
- States: IDLE, RUN, DRAIN, HALT.
- IDLE: imem_addr = 0; the memory loads its image while addressed at 0. start with prog_sel 0..2 -> RUN with fetch_pc = base. start with prog_sel 3 -> HALT, fault = 1.
- RUN, no stall: imem_addr = fetch_pc; pend_pc <= fetch_pc; pend_valid <= 1; fetch_pc <= fetch_pc + 1.
- Output register loads imem_data/pend_pc when pend_valid and (!instr_valid or instr_ready); instr_valid clears when accepted with nothing pending.
- Stall = instr_valid && !instr_ready: fetch_pc and pend state hold; imem_addr = pend_pc, so the memory re-reads the same word and imem_data stays stable.
- fetch_pc reaches limit -> DRAIN: no new issue (imem_addr = pend_pc); when pend_valid = 0 and instr_valid = 0 -> HALT.
- Redirect (highest priority, RUN or DRAIN): instr_valid <= 0 (flush); target in window -> imem_addr = redirect_pc same cycle, pend_pc <= redirect_pc, pend_valid <= 1, fetch_pc <= redirect_pc + 1, state RUN. Target out of window -> pend_valid <= 0, fault <= 1, HALT. Ignored in IDLE/HALT.
- start in RUN/DRAIN ignored. start in HALT clears fault and relaunches exactly as from IDLE.
- fetch_pc arithmetic is ADDR_W bits, no wrap reachable (limit ≤ 81).

## Timing
- Reset (async): state IDLE, fetch_pc 0, pend_valid 0, imem_addr 0, instr 0, instr_pc 0, instr_valid 0, running 0, halted 0, fault 0.
- start sampled at edge E0 -> base presented after E0, captured by memory at E1, instr_valid = 1 with instr_pc = base after E2 (2-cycle latency).
- Throughput one instruction per cycle while instr_ready = 1.
- Redirect at edge Er -> target instruction valid after Er+1 (one bubble).
- Reset mid-operation discards all in-flight words immediately.

## Configuration
- FETCH_PERF_CNT_EN defined: extra outputs fetch_count[15:0] (instructions accepted by decoder) and stall_count[15:0] (stall cycles), both saturating at 16'hFFFF, cleared by reset and by start. Undefined: ports and logic absent; all other behaviour identical.

## Structure
- Shared package mips_fetch_pkg: ADDR_W/DATA_W defaults, PROG_BASE and PROG_LIMIT constant arrays, fetch state enum.
- One natural sub-module: fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN.

## Test plan
- Reset, start, prog_sel 0, instr_ready 1, memory model of 81 words -> instr_pc 0..14 on consecutive cycles from E0+2, then halted = 1, fault 0.
- prog_sel 1, hold instr_ready 0 for 3 cycles at instr_pc 17 -> instr/instr_pc stable, imem_addr = 18 throughout, no word lost or duplicated.
- prog_sel 0, redirect_pc 6 while instr_pc = 9 -> 9's successor flushed, next valid instr_pc = 6 one bubble later.
- prog_sel 1, redirect_pc 40 -> fault = 1, halted = 1, instr_valid 0; later start with prog_sel 2 -> fault clears, instr_pc 30 after 2 cycles.
- prog_sel 3 start -> halted = 1, fault = 1, imem_addr 0; reset_n low mid-RUN of prog 2 -> all outputs at reset values immediately.
- With FETCH_PERF_CNT_EN, prog 0 with 4 stall cycles -> fetch_count = 15, stall_count = 4.
